// File: rtl/fifo_axis_packer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : packer_pkg                                                     |
// | Purpose    : Shared constants and helpers for the FIFO-to-AXI4-Stream      |
// |              byte packer (fifo_axis_packer and its output register).       |
// | Contents   : default geometry (IN_W, LANES, FRAME_LEN), counter widths,    |
// |              keep_mask() helper producing a low-aligned tkeep pattern.     |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package packer_pkg;

   localparam int DEF_IN_W      = 8;
   localparam int DEF_LANES     = 4;
   localparam int DEF_FRAME_LEN = 1024;

   // Frame byte counter width; FRAME_LEN may be anything from 1 to 2^20-1.
   localparam int FRAME_CNT_W   = 20;

   // Width of the optional statistics counters.
   localparam int STAT_W        = 16;

   // Largest lane count the keep helper can describe.
   localparam int MAX_LANES     = 64;

   // Returns 'count' ones packed at the bottom: the tkeep for a beat whose
   // first 'count' lanes carry bytes. Callers slice the low LANES bits.
   function automatic logic [MAX_LANES-1:0] keep_mask(input int count);
      logic [MAX_LANES-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_LANES; i++) begin
         if (i < count) begin
            m[i] = 1'b1;
         end
      end
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_axis_packer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface  : fifo_axis_packer_if                                           |
// | Purpose    : Bundles the byte-FIFO pop port and the AXI4-Stream master     |
// |              port of the packer.                                           |
// | Signals    : fifo_valid, fifo_data, fifo_enr      (FIFO side)              |
// |              m_tdata, m_tkeep, m_tlast, m_tvalid, m_tready (stream side)   |
// | Modports   : master - the packer (pops FIFO, drives the stream)            |
// |              slave  - the environment (FIFO model and stream sink)         |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface fifo_axis_packer_if #(
   parameter int IN_W  = 8,
   parameter int LANES = 4
);

   logic                  fifo_valid;
   logic [IN_W-1:0]       fifo_data;
   logic                  fifo_enr;

   logic [LANES*IN_W-1:0] m_tdata;
   logic [LANES-1:0]      m_tkeep;
   logic                  m_tlast;
   logic                  m_tvalid;
   logic                  m_tready;

   modport master (
      input  fifo_valid,
      input  fifo_data,
      output fifo_enr,
      output m_tdata,
      output m_tkeep,
      output m_tlast,
      output m_tvalid,
      input  m_tready
   );

   modport slave (
      output fifo_valid,
      output fifo_data,
      input  fifo_enr,
      input  m_tdata,
      input  m_tkeep,
      input  m_tlast,
      input  m_tvalid,
      output m_tready
   );

endinterface
`default_nettype wire

// File: rtl/fifo_axis_packer_out_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : axis_out_reg                                                  |
// | Purpose    : Single-entry AXI4-Stream output register. Holds a beat stable |
// |              while the sink stalls; accepts a new beat whenever it is      |
// |              empty or its current beat is draining this cycle.             |
// | Ports      : clk, rst            - clock, synchronous active-high reset    |
// |              load, load_*        - new beat from the producer              |
// |              can_load            - register can take a beat this cycle     |
// |              tdata/tkeep/tlast/tvalid, tready - stream master port         |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module axis_out_reg #(
   parameter int DATA_W = 32,
   parameter int KEEP_W = 4
) (
   input  wire               clk,
   input  wire               rst,
   input  wire               load,
   input  wire  [DATA_W-1:0] load_data,
   input  wire  [KEEP_W-1:0] load_keep,
   input  wire               load_last,
   output logic              can_load,
   output logic [DATA_W-1:0] tdata,
   output logic [KEEP_W-1:0] tkeep,
   output logic              tlast,
   output logic              tvalid,
   input  wire               tready
);

   // Depends on tready only toward the producer; tvalid itself is a flop.
   assign can_load = !tvalid || tready;

   always_ff @(posedge clk) begin
      if (rst) begin
         tdata  <= '0;
         tkeep  <= '0;
         tlast  <= 1'b0;
         tvalid <= 1'b0;
      end else if (load) begin
         // Covers both an empty register and a back-to-back replace.
         tdata  <= load_data;
         tkeep  <= load_keep;
         tlast  <= load_last;
         tvalid <= 1'b1;
      end else if (tvalid && tready) begin
         tvalid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fifo_axis_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : fifo_axis_packer                                              |
// | Purpose    : Pops IN_W-bit pixels from the byte FIFO and packs LANES of    |
// |              them per AXI4-Stream beat. Frames of FRAME_LEN bytes end on   |
// |              a tlast beat whose tkeep marks the filled lanes; frames never |
// |              share a beat. Sustains one pop per cycle while tready is high.|
// | Ports      : clk, rst - clock, synchronous active-high reset               |
// |              bus      - fifo_axis_packer_if.master (FIFO pop + stream out) |
// |              stat_frames, stat_stalls - only with PACKER_STATS_EN          |
// | Options    : PACKER_STATS_EN - adds frame (wrapping) and stall (saturating)|
// |              counters.                                                     |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module fifo_axis_packer
   import packer_pkg::*;
#(
   parameter int IN_W      = DEF_IN_W,
   parameter int LANES     = DEF_LANES,
   parameter int FRAME_LEN = DEF_FRAME_LEN
) (
   input  wire                clk,
   input  wire                rst,
   fifo_axis_packer_if.master bus
`ifdef PACKER_STATS_EN
   ,
   output logic [STAT_W-1:0]  stat_frames,
   output logic [STAT_W-1:0]  stat_stalls
`endif
);

   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int OUT_W  = LANES * IN_W;

   localparam logic [LANE_W-1:0]      LAST_LANE = LANE_W'(LANES - 1);
   localparam logic [FRAME_CNT_W-1:0] LAST_BYTE = FRAME_CNT_W'(FRAME_LEN - 1);

   // Fill side: word under assembly, or a finished word parked behind a
   // stalled output register (r_fill_rdy).
   logic [LANE_W-1:0]      r_lane_idx;
   logic [FRAME_CNT_W-1:0] r_frame_cnt;
   logic [OUT_W-1:0]       r_fill;
   logic                   r_fill_rdy;
   logic [LANES-1:0]       r_fill_keep;
   logic                   r_fill_last;

   logic                   w_enr;
   logic                   w_pop;
   logic                   w_frame_end;
   logic                   w_done;
   logic                   w_out_free;
   logic                   w_stall;
   logic                   w_load;
   logic                   w_park;
   logic [OUT_W-1:0]       w_word;
   logic [MAX_LANES-1:0]   w_mask;
   logic [LANES-1:0]       w_keep_new;
   logic [OUT_W-1:0]       w_load_data;
   logic [LANES-1:0]       w_load_keep;
   logic                   w_load_last;
   logic [OUT_W-1:0]       w_tdata;
   logic [LANES-1:0]       w_tkeep;
   logic                   w_tlast;
   logic                   w_tvalid;

   // Only a parked word facing a blocked output stops popping; a word
   // finishing this cycle can always go straight out or be parked.
   assign w_stall     = r_fill_rdy && !w_out_free;
   assign w_enr       = bus.fifo_valid && !w_stall && !rst;
   assign w_pop       = w_enr && bus.fifo_valid;
   assign bus.fifo_enr = w_enr;

   assign w_frame_end = (r_frame_cnt == LAST_BYTE);
   assign w_done      = w_pop && ((r_lane_idx == LAST_LANE) || w_frame_end);

   // A parked word always has priority; otherwise a word completing now is
   // loaded in the same cycle as its last pop.
   assign w_load      = (r_fill_rdy || w_done) && w_out_free;
   assign w_park      = w_done && (r_fill_rdy || !w_out_free);

   assign w_mask      = keep_mask(int'(r_lane_idx) + 1);
   assign w_keep_new  = w_mask[LANES-1:0];

   // Once the parked word leaves, new bytes start from an all-zero word so
   // unused lanes of a short final beat read as zero.
   always_comb begin
      w_word = r_fill_rdy ? '0 : r_fill;
      if (w_pop) begin
         w_word[int'(r_lane_idx)*IN_W +: IN_W] = bus.fifo_data;
      end
   end

   assign w_load_data = r_fill_rdy ? r_fill      : w_word;
   assign w_load_keep = r_fill_rdy ? r_fill_keep : w_keep_new;
   assign w_load_last = r_fill_rdy ? r_fill_last : w_frame_end;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_lane_idx  <= '0;
         r_frame_cnt <= '0;
         r_fill      <= '0;
         r_fill_rdy  <= 1'b0;
         r_fill_keep <= '0;
         r_fill_last <= 1'b0;
      end else begin
         if (w_pop) begin
            r_lane_idx  <= w_done      ? '0 : r_lane_idx + 1'b1;
            r_frame_cnt <= w_frame_end ? '0 : r_frame_cnt + 1'b1;
         end
         if (!w_stall) begin
            if (w_park) begin
               r_fill      <= w_word;
               r_fill_rdy  <= 1'b1;
               r_fill_keep <= w_keep_new;
               r_fill_last <= w_frame_end;
            end else begin
               r_fill      <= w_done ? '0 : w_word;
               r_fill_rdy  <= 1'b0;
            end
         end
      end
   end

   axis_out_reg #(
      .DATA_W (OUT_W),
      .KEEP_W (LANES)
   ) u_out_reg (
      .clk       (clk),
      .rst       (rst),
      .load      (w_load),
      .load_data (w_load_data),
      .load_keep (w_load_keep),
      .load_last (w_load_last),
      .can_load  (w_out_free),
      .tdata     (w_tdata),
      .tkeep     (w_tkeep),
      .tlast     (w_tlast),
      .tvalid    (w_tvalid),
      .tready    (bus.m_tready)
   );

   assign bus.m_tdata  = w_tdata;
   assign bus.m_tkeep  = w_tkeep;
   assign bus.m_tlast  = w_tlast;
   assign bus.m_tvalid = w_tvalid;

`ifdef PACKER_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_frames <= '0;
         stat_stalls <= '0;
      end else begin
         if (w_tvalid && bus.m_tready && w_tlast) begin
            stat_frames <= stat_frames + 1'b1;
         end
         if (w_tvalid && !bus.m_tready && (stat_stalls != '1)) begin
            stat_stalls <= stat_stalls + 1'b1;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_axis_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_fifo_axis_packer                                           |
// | Purpose    : Self-checking bench for fifo_axis_packer. Three instances     |
// |              (FRAME_LEN 1024, 6 and 1) are fed from queue-based FIFO       |
// |              models; expected beats are produced by a reference packer    |
// |              model when bytes are pushed and compared as beats are taken. |
// | Options    : PACKER_STATS_EN - also checks the statistics counters.        |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_fifo_axis_packer;
   import packer_pkg::*;

   localparam int NI = 3;
   localparam int FL_TAB [NI] = '{1024, 6, 1};

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   logic        vld  [NI];
   logic [7:0]  dat  [NI];
   logic        enr  [NI];
   logic        rdy  [NI];
   logic [31:0] td   [NI];
   logic [3:0]  tk   [NI];
   logic        tl   [NI];
   logic        tv   [NI];
`ifdef PACKER_STATS_EN
   logic [15:0] sfr  [NI];
   logic [15:0] sst  [NI];
`endif

   logic        gate     [NI];
   logic        pop_pend [NI];
   logic [7:0]  fifo_q   [NI][$];
   beat_t       exp_q    [NI][$];

   logic [31:0] m_part [NI];
   int          m_lane [NI];
   int          m_fpos [NI];

   int total = 0;
   int bad   = 0;

   genvar gi;
   generate
      for (gi = 0; gi < NI; gi++) begin : g_dut
         fifo_axis_packer_if #(.IN_W(8), .LANES(4)) bus ();
         assign bus.fifo_valid = vld[gi];
         assign bus.fifo_data  = dat[gi];
         assign bus.m_tready   = rdy[gi];
         assign enr[gi]        = bus.fifo_enr;
         assign td[gi]         = bus.m_tdata;
         assign tk[gi]         = bus.m_tkeep;
         assign tl[gi]         = bus.m_tlast;
         assign tv[gi]         = bus.m_tvalid;

         fifo_axis_packer #(
            .IN_W      (8),
            .LANES     (4),
            .FRAME_LEN (FL_TAB[gi])
         ) dut (
            .clk         (clk),
            .rst         (rst),
            .bus         (bus)
`ifdef PACKER_STATS_EN
            ,
            .stat_frames (sfr[gi]),
            .stat_stalls (sst[gi])
`endif
         );
      end
   endgenerate

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference packer: queue the byte in the FIFO model and emit an
   // expected beat when a word fills or the frame ends.
   task automatic push_byte(input int id, input logic [7:0] b);
      beat_t e;
      fifo_q[id].push_back(b);
      m_part[id][8*m_lane[id] +: 8] = b;
      m_lane[id]++;
      m_fpos[id]++;
      if (m_lane[id] == 4 || m_fpos[id] == FL_TAB[id]) begin
         e.data = m_part[id];
         e.keep = 4'((1 << m_lane[id]) - 1);
         e.last = (m_fpos[id] == FL_TAB[id]);
         exp_q[id].push_back(e);
         m_part[id] = '0;
         m_lane[id] = 0;
         if (e.last) m_fpos[id] = 0;
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         exp_q[i].delete();
         m_part[i] = '0;
         m_lane[i] = 0;
         m_fpos[i] = 0;
      end
   endtask

   task automatic drain(input int id);
      int n;
      n = 0;
      while ((exp_q[id].size() != 0 || fifo_q[id].size() != 0) && n < 300) begin
         tick();
         n++;
      end
      chk_eq($sformatf("drain%0d_left", id), exp_q[id].size() + fifo_q[id].size(), 0);
   endtask

   task automatic rand_run(input int id, input int n);
      int c;
      for (int k = 0; k < n; k++) push_byte(id, 8'($urandom_range(0, 255)));
      c = 0;
      while ((exp_q[id].size() != 0 || fifo_q[id].size() != 0) && c < 2000) begin
         gate[id] = ($urandom_range(0, 3) != 0);
         rdy[id]  = ($urandom_range(0, 2) != 0);
         tick();
         c++;
      end
      chk_eq($sformatf("rand%0d_left", id), exp_q[id].size() + fifo_q[id].size(), 0);
      gate[id] = 1'b1;
      rdy[id]  = 1'b1;
   endtask

   // FIFO model: applies last cycle's pop, then presents the head byte.
   always @(posedge clk) begin
      #2;
      for (int i = 0; i < NI; i++) begin
         if (pop_pend[i] && fifo_q[i].size() > 0) void'(fifo_q[i].pop_front());
         pop_pend[i] = 1'b0;
         vld[i] = gate[i] && (fifo_q[i].size() > 0);
         dat[i] = (fifo_q[i].size() > 0) ? fifo_q[i][0] : 8'h00;
      end
   end

   // Monitor: inputs are settled at the falling edge, so what is seen here
   // is what the DUT acts on at the next rising edge.
   logic        hold_prev [NI];
   logic [31:0] prev_td   [NI];
   logic [3:0]  prev_tk   [NI];
   logic        prev_tl   [NI];

   always @(negedge clk) begin : mon
      beat_t e;
      for (int i = 0; i < NI; i++) begin
         if (vld[i] && enr[i]) pop_pend[i] = 1'b1;
         if (rst) begin
            hold_prev[i] = 1'b0;
         end else begin
            if (hold_prev[i]) begin
               chk_eq($sformatf("hold%0d_valid", i), tv[i], 1'b1);
               chk_eq($sformatf("hold%0d_data", i), td[i], prev_td[i]);
               chk_eq($sformatf("hold%0d_keep", i), tk[i], prev_tk[i]);
               chk_eq($sformatf("hold%0d_last", i), tl[i], prev_tl[i]);
            end
            if (tv[i] && rdy[i]) begin
               if (exp_q[i].size() == 0) begin
                  chk_eq($sformatf("beat%0d_unexpected", i), 1, 0);
               end else begin
                  e = exp_q[i].pop_front();
                  chk_eq($sformatf("beat%0d_data", i), td[i], e.data);
                  chk_eq($sformatf("beat%0d_keep", i), tk[i], e.keep);
                  chk_eq($sformatf("beat%0d_last", i), tl[i], e.last);
               end
            end
            hold_prev[i] = tv[i] && !rdy[i];
            prev_td[i]   = td[i];
            prev_tk[i]   = tk[i];
            prev_tl[i]   = tl[i];
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [11:0] mask;
      int n, pops, last_pop, first_tv;

      rst = 1'b1;
      for (int i = 0; i < NI; i++) begin
         gate[i] = 1'b0; rdy[i] = 1'b0; vld[i] = 1'b0; dat[i] = '0;
         pop_pend[i] = 1'b0; hold_prev[i] = 1'b0;
      end
      model_reset();

      // Reset state, with a byte offered so fifo_enr is really exercised.
      fifo_q[0].push_back(8'h55);
      gate[0] = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      chk_eq("rst_tvalid", tv[0], 1'b0);
      chk_eq("rst_tlast",  tl[0], 1'b0);
      chk_eq("rst_tkeep",  tk[0], 4'h0);
      chk_eq("rst_tdata",  td[0], 32'h0);
      chk_eq("rst_enr",    enr[0], 1'b0);
      tick();
      fifo_q[0].delete();
      gate[0] = 1'b0;
      rst = 1'b0;
      tick();

      // Full-rate streaming: 8 consecutive pops, two full beats.
      rdy[0] = 1'b1;
      for (int k = 1; k <= 8; k++) push_byte(0, 8'(k));
      gate[0] = 1'b1;
      mask = '0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (enr[0]) mask[c] = 1'b1;
      end
      chk_eq("t1_enr_run", mask, 12'h0FF);
      drain(0);

      // Sink stall of 10 cycles right after the first beat appears.
      rdy[0] = 1'b0;
      for (int k = 0; k < 12; k++) push_byte(0, 8'(8'h10 + k));
      n = 0;
      @(negedge clk);
      while (!tv[0] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk_eq("t2_tvalid_seen", tv[0], 1'b1);
      pops = 0;
      for (int c = 0; c < 10; c++) begin
         if (c > 0) @(negedge clk);
         if (enr[0] && vld[0]) pops++;
      end
      chk_eq("t2_pops_in_stall", pops, 4);
      chk_eq("t2_enr_stalled", enr[0], 1'b0);
      chk_eq("t2_held_data", td[0], 32'h13121110);
      tick();
      rdy[0] = 1'b1;
      drain(0);
`ifdef PACKER_STATS_EN
      chk_eq("t2_stat_stalls", sst[0], 16'd10);
`endif

      // Sparse input: valid every other cycle, beat one cycle after 4th pop.
      for (int k = 0; k < 4; k++) push_byte(0, 8'(8'hA0 + k));
      pops = 0; last_pop = -1; first_tv = -1;
      for (int c = 0; c < 12; c++) begin
         gate[0] = ((c % 2) == 0);
         @(negedge clk);
         if (enr[0] && vld[0]) begin
            pops++;
            if (pops == 4) last_pop = c;
         end
         if (tv[0] && first_tv < 0) first_tv = c;
         tick();
      end
      chk_eq("t4_pops", pops, 4);
      chk_eq("t4_latency", first_tv - last_pop, 1);
      gate[0] = 1'b1;
      drain(0);

      // FRAME_LEN = 6: keep F/3 with tlast, twice.
      rdy[1] = 1'b1;
      for (int k = 0; k < 12; k++) push_byte(1, 8'(8'h60 + k));
      gate[1] = 1'b1;
      drain(1);
`ifdef PACKER_STATS_EN
      chk_eq("t6_stat_frames", sfr[1], 16'd2);
`endif

      // FRAME_LEN = 1: every beat is a single-byte tlast beat.
      rdy[2] = 1'b1;
      for (int k = 0; k < 5; k++) push_byte(2, 8'(8'h70 + k));
      gate[2] = 1'b1;
      drain(2);

      // Random valid/ready; instance 1 ends mid-frame before the reset test.
      rand_run(0, 32);
      rand_run(1, 29);
      rand_run(2, 20);

      // Reset with a pending beat and a 2-byte partial word.
      rdy[0] = 1'b0;
      for (int k = 0; k < 6; k++) push_byte(0, 8'(8'hB0 + k));
      gate[0] = 1'b1;
      repeat (10) tick();
      chk_eq("t5_pending", tv[0], 1'b1);
      chk_eq("t5_fifo_emptied", fifo_q[0].size(), 0);
      rst = 1'b1;
      model_reset();
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk_eq("t5_tvalid_cleared", tv[0], 1'b0);
      chk_eq("t5_tvalid_cleared1", tv[1], 1'b0);
      rdy[0] = 1'b1;
      for (int k = 0; k < 4; k++) push_byte(0, 8'(8'hC0 + k));
      drain(0);
      // Frame counter of the FRAME_LEN=6 instance restarts from byte 0.
      for (int k = 0; k < 6; k++) push_byte(1, 8'(8'hD0 + k));
      drain(1);

      repeat (4) tick();
      for (int i = 0; i < NI; i++) begin
         chk_eq($sformatf("end%0d_exp_left", i), exp_q[i].size(), 0);
         chk_eq($sformatf("end%0d_tvalid", i), tv[i], 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
